// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension stage: mode encodings and mode field width.
package imm_ext_pkg;

    localparam int IMM_MODE_W = 2;

    localparam logic [IMM_MODE_W-1:0] MODE_SEXT      = 2'd0;
    localparam logic [IMM_MODE_W-1:0] MODE_ZEXT      = 2'd1;
    localparam logic [IMM_MODE_W-1:0] MODE_UPPER     = 2'd2;
    localparam logic [IMM_MODE_W-1:0] MODE_SEXT_SHL2 = 2'd3;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Stream bus for the immediate-extension stage: upstream offer side plus downstream result side.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    import imm_ext_pkg::*;

    // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
    // The producer holds its payload while valid & !ready; ready never depends combinationally on valid.
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_imm;
    logic [IMM_MODE_W-1:0] in_mode;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_imm;
    logic [TAG_W-1:0]      out_tag;
    logic [1:0]            dbg_occ;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, dbg_occ
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, dbg_occ
    );

endinterface

// File: rtl/imm_extend_core.sv
// Combinational widening of an IN_W immediate to OUT_W according to the extension mode.
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [OUT_W-1:0]      ext
);

    localparam int E = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{E{imm[IN_W-1]}}, imm};

    // Shifting the sign-extended value keeps the branch-offset case free of a zero-width replication.
    always_comb begin
        ext = sext;
        case (mode)
            MODE_SEXT:      ext = sext;
            MODE_ZEXT:      ext = {{E{1'b0}}, imm};
            MODE_UPPER:     ext = {imm, {E{1'b0}}};
            MODE_SEXT_SHL2: ext = sext << 2;
            default:        ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a main output register and one skid entry,
// so downstream back-pressure never drops an accepted immediate.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_extend_pipe_if.slave bus
);

    if (IN_W < 2) begin : g_bad_in_w
        $error("imm_extend_pipe: IN_W must be at least 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] ext;

    imm_extend_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) u_core (
        .imm (bus.in_imm),
        .mode(bus.in_mode),
        .ext (ext)
    );

    logic             out_valid_q;
    logic [OUT_W-1:0] out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             skid_valid_q;
    logic [OUT_W-1:0] skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic accept;
    logic main_load;

    assign accept    = bus.in_valid & ~skid_valid_q;
    assign main_load = ~out_valid_q | bus.out_ready;

    // Occupancy flags: skid_valid_q is only ever set while the main register is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_load) begin
            out_valid_q  <= skid_valid_q | accept;
            skid_valid_q <= 1'b0;
        end else if (accept) begin
            skid_valid_q <= 1'b1;
        end
    end

    // Payload registers; a flush leaves them untouched since their value is then don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
        end else if (!flush) begin
            if (main_load) begin
                if (skid_valid_q) begin
                    out_imm_q <= skid_imm_q;
                    out_tag_q <= skid_tag_q;
                end else if (accept) begin
                    out_imm_q <= ext;
                    out_tag_q <= bus.in_tag;
                end
            end else if (accept) begin
                skid_imm_q <= ext;
                skid_tag_q <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.dbg_occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: constant vector tables, hand-built stall/flush/reset sequences,
// and a random phase scored against an arithmetic reference model.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int TAG_W  = 5;
    localparam int IN_W2  = 12;
    localparam int OUT_W2 = 20;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic flush;
    logic flush2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(IN_W),  .OUT_W(OUT_W),  .TAG_W(TAG_W)) ifc  ();
    imm_extend_pipe_if #(.IN_W(IN_W2), .OUT_W(OUT_W2), .TAG_W(TAG_W)) ifc2 ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (ifc)
    );

    imm_extend_pipe #(.IN_W(IN_W2), .OUT_W(OUT_W2), .TAG_W(TAG_W)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush2),
        .bus  (ifc2)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [TAG_W+OUT_W-1:0] exp_q[$];
    logic mon_en = 1'b0;
    logic acc_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from the signed/unsigned value of the field, using plain arithmetic.
    function automatic longint unsigned ref_ext(input int in_w, input int out_w, input int mode,
                                                input longint unsigned imm);
        longint          sval;
        longint unsigned res;
        longint unsigned mask;
        mask = (64'd1 << out_w) - 64'd1;
        if (((imm >> (in_w - 1)) & 64'd1) != 0) sval = longint'(imm) - (longint'(1) << in_w);
        else                                    sval = longint'(imm);
        case (mode)
            0:       res = longint'(sval);
            1:       res = imm;
            2:       res = imm * (64'd1 << (out_w - in_w));
            default: res = longint'(sval * 4);
        endcase
        return res & mask;
    endfunction

    // Model state is the ordered list of accepted-but-not-emitted entries.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("out_valid_vs_model", 64'(ifc.out_valid), 64'(exp_q.size() > 0));
            chk("in_ready_vs_model", 64'(ifc.in_ready), 64'(exp_q.size() < 2));
            chk("dbg_occ_vs_model", 64'(ifc.dbg_occ), 64'(exp_q.size()));
            if (ifc.out_valid && exp_q.size() > 0)
                chk("out_tag_imm_vs_model", 64'({ifc.out_tag, ifc.out_imm}), 64'(exp_q[0]));
            acc_seen = ifc.in_valid && ifc.in_ready;
            if (ifc.out_valid && ifc.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (acc_seen)
                exp_q.push_back({ifc.in_tag,
                                 OUT_W'(ref_ext(IN_W, OUT_W, int'(ifc.in_mode), 64'(ifc.in_imm)))});
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] imm,
                         input logic [TAG_W-1:0] tag);
        ifc.in_valid = v;
        ifc.in_mode  = m;
        ifc.in_imm   = imm;
        ifc.in_tag   = tag;
    endtask

    task automatic drive2(input logic v, input logic [1:0] m, input logic [IN_W2-1:0] imm);
        ifc2.in_valid = v;
        ifc2.in_mode  = m;
        ifc2.in_imm   = imm;
        ifc2.in_tag   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  imm;
        logic [OUT_W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]        mode;
        logic [IN_W2-1:0]  imm;
        logic [OUT_W2-1:0] exp;
    } vec2_t;

    vec_t  vt[10];
    vec2_t vt2[4];

    logic [TAG_W-1:0] rx_tags[$];
    logic [TAG_W-1:0] tag_next;
    logic             acc;

    initial begin
        vt[0] = '{MODE_SEXT,      16'h8001, 32'hFFFF8001};
        vt[1] = '{MODE_ZEXT,      16'h8001, 32'h00008001};
        vt[2] = '{MODE_UPPER,     16'h1234, 32'h12340000};
        vt[3] = '{MODE_SEXT_SHL2, 16'hFFFF, 32'hFFFFFFFC};
        vt[4] = '{MODE_SEXT_SHL2, 16'h0004, 32'h00000010};
        vt[5] = '{MODE_SEXT,      16'h7FFF, 32'h00007FFF};
        vt[6] = '{MODE_ZEXT,      16'hFFFF, 32'h0000FFFF};
        vt[7] = '{MODE_UPPER,     16'hFFFF, 32'hFFFF0000};
        vt[8] = '{MODE_SEXT_SHL2, 16'h8000, 32'hFFFE0000};
        vt[9] = '{MODE_SEXT,      16'h0000, 32'h00000000};
        vt2[0] = '{MODE_SEXT,      12'h800, 20'hFF800};
        vt2[1] = '{MODE_UPPER,     12'hABC, 20'hABC00};
        vt2[2] = '{MODE_ZEXT,      12'h800, 20'h00800};
        vt2[3] = '{MODE_SEXT_SHL2, 12'h800, 20'hFE000};

        rst_n = 1'b0;
        flush = 1'b0;
        flush2 = 1'b0;
        drive(1'b0, MODE_SEXT, '0, '0);
        ifc.out_ready = 1'b1;
        drive2(1'b0, MODE_SEXT, '0);
        ifc2.out_ready = 1'b1;

        // Reset state
        #12;
        chk("reset_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("reset_out_imm", 64'(ifc.out_imm), 64'd0);
        chk("reset_out_tag", 64'(ifc.out_tag), 64'd0);
        chk("reset_in_ready", 64'(ifc.in_ready), 64'd1);
        #5;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Back-to-back table vectors, one-cycle latency
        tick();
        drive(1'b1, vt[0].mode, vt[0].imm, 5'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("table_valid", 64'(ifc.out_valid), 64'd1);
            chk("table_imm", 64'(ifc.out_imm), 64'(vt[i].exp));
            chk("table_tag", 64'(ifc.out_tag), 64'(i));
            if (i < 9) drive(1'b1, vt[i+1].mode, vt[i+1].imm, TAG_W'(i + 1));
            else       drive(1'b0, MODE_SEXT, '0, '0);
        end
        tick();

        // Narrow instance
        drive2(1'b1, vt2[0].mode, vt2[0].imm);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("narrow_valid", 64'(ifc2.out_valid), 64'd1);
            chk("narrow_imm", 64'(ifc2.out_imm), 64'(vt2[i].exp));
            if (i < 3) drive2(1'b1, vt2[i+1].mode, vt2[i+1].imm);
            else       drive2(1'b0, MODE_SEXT, '0);
        end
        tick();

        // Stall with two held entries, then release: tags 1..4 in order
        tag_next = 5'd1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            ifc.out_ready = !(cyc >= 1 && cyc <= 3);
            drive(tag_next <= 5'd4, MODE_ZEXT, IN_W'(tag_next), tag_next);
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
                chk("stall_out_tag", 64'(ifc.out_tag), 64'd1);
                chk("stall_out_imm", 64'(ifc.out_imm), 64'd1);
            end
            acc = ifc.in_valid && ifc.in_ready;
            if (ifc.out_valid && ifc.out_ready) rx_tags.push_back(ifc.out_tag);
            tick();
            if (acc) tag_next = tag_next + 5'd1;
        end
        chk("stall_rx_count", 64'(rx_tags.size()), 64'd4);
        for (int i = 0; i < 4 && i < rx_tags.size(); i++)
            chk("stall_rx_order", 64'(rx_tags[i]), 64'(i + 1));

        // Flush with main and skid full
        ifc.out_ready = 1'b0;
        drive(1'b1, MODE_ZEXT, 16'd10, 5'd10);
        tick();
        drive(1'b1, MODE_ZEXT, 16'd11, 5'd11);
        tick();
        chk("full_in_ready", 64'(ifc.in_ready), 64'd0);
        drive(1'b1, MODE_ZEXT, 16'd12, 5'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, MODE_SEXT, '0, '0);
        chk("flush_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("flush_in_ready", 64'(ifc.in_ready), 64'd1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_nothing_emitted", 64'(ifc.out_valid), 64'd0);
            tick();
        end

        // Flush while the stage could accept: the offered entry must be discarded
        ifc.out_ready = 1'b0;
        drive(1'b1, MODE_ZEXT, 16'd13, 5'd13);
        tick();
        drive(1'b1, MODE_ZEXT, 16'd14, 5'd14);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, MODE_SEXT, '0, '0);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_accept_discarded", 64'(ifc.out_valid), 64'd0);
            tick();
        end

        // Asynchronous reset between edges with entries held
        ifc.out_ready = 1'b0;
        drive(1'b1, MODE_ZEXT, 16'd20, 5'd20);
        tick();
        drive(1'b1, MODE_ZEXT, 16'd21, 5'd21);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("async_rst_occ", 64'(ifc.dbg_occ), 64'd0);
        drive(1'b0, MODE_SEXT, '0, '0);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        drive(1'b1, MODE_SEXT, 16'h8001, 5'd3);
        tick();
        drive(1'b0, MODE_SEXT, '0, '0);
        chk("restart_out_valid", 64'(ifc.out_valid), 64'd1);
        chk("restart_out_imm", 64'(ifc.out_imm), 64'hFFFF8001);
        tick();

        // Random traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!(ifc.in_valid && !acc_seen))
                drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                      IN_W'($urandom), TAG_W'($urandom));
            ifc.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 40) == 0;
            tick();
        end
        flush = 1'b0;
        drive(1'b0, MODE_SEXT, '0, '0);
        ifc.out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("drain_model_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
